// File: rtl/huffman_stream_packer.sv
// Avalon-MM Huffman encoder: symbol -> LUT codeword, packed MSB-first into OUT_W-bit words.
// Two-stage pipeline (sample, LUT read) then accumulator append; flush stalls the bus until drained.
module huffman_stream_packer #(
  parameter int SYM_W   = 6,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int OUT_W   = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic             read,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             waitrequest,
  output logic [OUT_W-1:0] encoded_out,
  output logic             enable_out
);

  localparam int DEPTH  = 2 ** SYM_W;
  localparam int FILL_W = $clog2(OUT_W);
  localparam int W2     = OUT_W + MAX_LEN;
  localparam int SH_W   = $clog2(W2 + 1);
  localparam int LUT_FW = SYM_W + MAX_LEN + LEN_W;

  logic [MAX_LEN-1:0] lut_code [DEPTH];
  logic [LEN_W-1:0]   lut_len  [DEPTH];

  logic               flush_pending;
  logic               wr_acc, rd_acc;
  logic               s0_valid, s1_valid;
  logic [SYM_W-1:0]   s0_sym;
  logic [MAX_LEN-1:0] s1_code;
  logic [LEN_W-1:0]   s1_len;
  logic [LEN_W-1:0]   raw_len, clamp_len;
  logic [OUT_W-1:0]   acc;
  logic [FILL_W-1:0]  fill;
  logic [15:0]        word_count;
  logic [MAX_LEN-1:0] code_m;
  logic [SH_W-1:0]    total, sh;
  logic [W2-1:0]      merged;
  logic [31:0]        status;
  logic               unused_wdata;

  assign waitrequest  = flush_pending;
  assign wr_acc       = chipselect & write & ~waitrequest;
  assign rd_acc       = chipselect & read & ~waitrequest;
  assign unused_wdata = ^writedata[31:LUT_FW];

  // LUT is deliberately outside reset so software tables survive a block reset.
  always_ff @(posedge clock) begin
    if (wr_acc && address == 2'd0) begin
      lut_code[writedata[SYM_W-1:0]] <= writedata[SYM_W +: MAX_LEN];
      lut_len[writedata[SYM_W-1:0]]  <= writedata[SYM_W+MAX_LEN +: LEN_W];
    end
  end

  assign raw_len   = lut_len[s0_sym];
  assign clamp_len = (raw_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : raw_len;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s0_valid <= wr_acc && (address == 2'd1);
      s0_sym   <= writedata[SYM_W-1:0];
      s1_valid <= s0_valid;
      s1_code  <= lut_code[s0_sym];
      s1_len   <= clamp_len;
    end
  end

  // Code is placed just below the fill bits of an OUT_W+MAX_LEN window; overflow lands in the low MAX_LEN bits.
  always_comb begin
    code_m = s1_code & ~({MAX_LEN{1'b1}} << s1_len);
    total  = SH_W'(fill) + SH_W'(s1_len);
    sh     = SH_W'(W2) - total;
    merged = {acc, {MAX_LEN{1'b0}}} | (W2'(code_m) << sh);
    status = {word_count, 8'(fill), 6'b0, flush_pending, s1_valid};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc           <= '0;
      fill          <= '0;
      encoded_out   <= '0;
      enable_out    <= 1'b0;
      flush_pending <= 1'b0;
      word_count    <= '0;
      readdata      <= '0;
    end else begin
      enable_out <= 1'b0;
      if (s1_valid) begin
        if (total >= SH_W'(OUT_W)) begin
          encoded_out <= merged[W2-1 -: OUT_W];
          enable_out  <= 1'b1;
          acc         <= OUT_W'(merged[MAX_LEN-1:0]) << (OUT_W - MAX_LEN);
          fill        <= FILL_W'(total - SH_W'(OUT_W));
          word_count  <= word_count + 16'd1;
        end else begin
          acc  <= merged[W2-1 -: OUT_W];
          fill <= FILL_W'(total);
        end
      end else if (flush_pending) begin
        // Bits below fill are always zero, so acc is already the padded word.
        if (fill != '0) begin
          encoded_out <= acc;
          enable_out  <= 1'b1;
          word_count  <= word_count + 16'd1;
        end
        acc           <= '0;
        fill          <= '0;
        flush_pending <= 1'b0;
      end
      if (wr_acc && address == 2'd2 && writedata[0]) flush_pending <= 1'b1;
      if (rd_acc) readdata <= (address == 2'd3) ? status : 32'd0;
    end
  end

endmodule

// File: tb/tb_huffman_stream_packer.sv
// Directed bench for huffman_stream_packer: vector table of LUT/symbol runs plus flush, stall and reset sequences.
module tb_huffman_stream_packer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] encoded_out;
  logic        enable_out;

  huffman_stream_packer dut (
    .clock(clock), .resetn(resetn), .chipselect(chipselect), .address(address),
    .write(write), .read(read), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .encoded_out(encoded_out), .enable_out(enable_out)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          strobes = 0;
  logic [31:0] last_word = 32'd0;

  always @(posedge clock) begin
    #1;
    if (enable_out) begin
      strobes++;
      last_word = encoded_out;
    end
  end

  typedef struct {
    logic [5:0]  sym;
    logic [7:0]  code;
    logic [3:0]  len;
    int          reps;
    int          exp_strobes;
    logic [31:0] exp_word;
    int          exp_fill;
    logic        do_flush;
    logic [31:0] exp_flush;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1; stalls = 0;
    while (waitrequest && stalls < 20) begin
      @(negedge clock);
      stalls++;
    end
    if (waitrequest) begin
      checks++; errors++;
      $display("FAIL bus_write timeout: waitrequest stuck high after %0d cycles", stalls);
    end
    @(negedge clock);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    int n;
    n = 0;
    address = a; chipselect = 1'b1; read = 1'b1;
    while (waitrequest && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (waitrequest) begin
      checks++; errors++;
      $display("FAIL bus_read timeout: waitrequest stuck high after %0d cycles", n);
    end
    @(negedge clock);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  function automatic logic [31:0] lut_word(input logic [5:0] s, input logic [7:0] c, input logic [3:0] l);
    return {14'd0, l, c, s};
  endfunction

  initial begin
    logic [31:0] rd;
    int          s0;
    int          st;
    int          wc_model;
    wc_model = 0;

    vecs[0] = '{6'd0, 8'hAB, 4'd8,  4,  1, 32'hABABABAB, 0,  1'b0, 32'h0};
    vecs[1] = '{6'd1, 8'h05, 4'd3,  11, 1, 32'hB6DB6DB6, 1,  1'b1, 32'h80000000};
    vecs[2] = '{6'd2, 8'hFF, 4'd0,  50, 0, 32'h0,        0,  1'b0, 32'h0};
    vecs[3] = '{6'd3, 8'h5A, 4'd15, 4,  1, 32'h5A5A5A5A, 0,  1'b0, 32'h0};
    vecs[4] = '{6'd4, 8'hFE, 4'd2,  5,  0, 32'h0,        10, 1'b1, 32'hAA800000};
    vecs[5] = '{6'd5, 8'h01, 4'd1,  40, 1, 32'hFFFFFFFF, 8,  1'b1, 32'hFF000000};

    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("reset readdata", readdata, 32'd0);
    check("reset enable_out", 32'(enable_out), 32'd0);
    check("reset encoded_out", encoded_out, 32'd0);
    check("reset waitrequest", 32'(waitrequest), 32'd0);
    bus_read(2'd3, rd);
    check("reset status", rd, 32'd0);

    for (int i = 0; i < 6; i++) begin
      wr(2'd0, lut_word(vecs[i].sym, vecs[i].code, vecs[i].len));
      s0 = strobes;
      for (int k = 0; k < vecs[i].reps; k++) wr(2'd1, {26'd0, vecs[i].sym});
      repeat (4) @(negedge clock);
      check($sformatf("vec%0d strobes", i), strobes - s0, vecs[i].exp_strobes);
      if (vecs[i].exp_strobes > 0) check($sformatf("vec%0d word", i), last_word, vecs[i].exp_word);
      wc_model += vecs[i].exp_strobes;
      bus_read(2'd3, rd);
      check($sformatf("vec%0d fill", i), 32'(rd[15:8]), vecs[i].exp_fill);
      check($sformatf("vec%0d word_count", i), 32'(rd[31:16]), wc_model);
      if (vecs[i].do_flush) begin
        s0 = strobes;
        wr(2'd2, 32'd1);
        repeat (3) @(negedge clock);
        check($sformatf("vec%0d flush strobes", i), strobes - s0, 1);
        check($sformatf("vec%0d flush word", i), last_word, vecs[i].exp_flush);
        wc_model++;
        bus_read(2'd3, rd);
        check($sformatf("vec%0d post-flush fill", i), 32'(rd[15:8]), 32'd0);
        check($sformatf("vec%0d post-flush word_count", i), 32'(rd[31:16]), wc_model);
      end
    end

    // Empty flush: one stall cycle, no strobe, then the queued symbol goes through.
    s0 = strobes;
    bus_write(2'd2, 32'd1, st);
    check("empty flush waitrequest", 32'(waitrequest), 32'd1);
    bus_write(2'd1, 32'd0, st);
    check("symbol stall cycles", st, 32'd1);
    repeat (4) @(negedge clock);
    check("empty flush strobes", strobes - s0, 32'd0);
    bus_read(2'd3, rd);
    check("after stall fill", 32'(rd[15:8]), 32'd8);
    check("after stall word_count", 32'(rd[31:16]), wc_model);
    s0 = strobes;
    wr(2'd2, 32'd1);
    repeat (3) @(negedge clock);
    check("partial flush strobes", strobes - s0, 32'd1);
    check("partial flush word", last_word, 32'hAB000000);
    wc_model++;

    // LUT rewrite immediately followed by use; strobe two edges after the 4th symbol.
    wr(2'd0, lut_word(6'd0, 8'h12, 4'd8));
    s0 = strobes;
    for (int k = 0; k < 4; k++) wr(2'd1, 32'd0);
    check("rewrite strobe E1", strobes - s0, 32'd0);
    @(negedge clock);
    check("rewrite strobe E2-1", strobes - s0, 32'd0);
    @(negedge clock);
    check("rewrite strobe E2", strobes - s0, 32'd1);
    check("rewrite word", last_word, 32'h12121212);
    wc_model++;

    // Reset while a 20-bit flush is pending: nothing emitted, state cleared, LUT kept.
    for (int k = 0; k < 10; k++) wr(2'd1, 32'd4);
    repeat (3) @(negedge clock);
    bus_read(2'd3, rd);
    check("pre-reset fill", 32'(rd[15:8]), 32'd20);
    s0 = strobes;
    wr(2'd2, 32'd1);
    check("pre-reset flush pending", 32'(waitrequest), 32'd1);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("reset-mid-flush strobes", strobes - s0, 32'd0);
    bus_read(2'd3, rd);
    check("reset-mid-flush status", rd, 32'd0);
    s0 = strobes;
    for (int k = 0; k < 4; k++) wr(2'd1, 32'd0);
    repeat (4) @(negedge clock);
    check("lut retained strobes", strobes - s0, 32'd1);
    check("lut retained word", last_word, 32'h12121212);
    bus_read(2'd3, rd);
    check("lut retained status", rd, 32'h00010000);
    bus_read(2'd0, rd);
    check("addr0 read", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
